// File: rtl/lane_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stepmania_pkg
// Brief    : Shared types and constants for the lane event arbiter slice:
//            default lane count, lane index type, arbiter FSM states and
//            the judged-event record.
// Revision : 1.0  initial release
// ============================================================================
package stepmania_pkg;

    // Default geometry of the dance pad and the combo counter.
    localparam int DEFAULT_LANES   = 4;
    localparam int DEFAULT_COMBO_W = 8;

    // Lane index sized for the default lane count.
    typedef logic [$clog2(DEFAULT_LANES)-1:0] lane_idx_t;

    // Output register FSM: nothing presented / event presented.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    // One judged event as seen by the score/feedback logic.
    typedef struct packed {
        lane_idx_t lane;
        logic      hit;
    } lane_event_t;

    // Advance a lane index by one, wrapping back to lane 0 after the last lane.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : stepmania_pkg
`default_nettype wire

// File: rtl/lane_event_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. Searches the request vector
//            starting at ptr and returns the first requester as a one-hot
//            grant plus its index. Pointer state is owned by the parent.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import stepmania_pkg::*;
#(
    parameter  int LANES = DEFAULT_LANES,
    localparam int LW    = $clog2(LANES)
) (
    input  logic [LANES-1:0] req_i,
    input  logic [LW-1:0]    ptr_i,
    output logic [LANES-1:0] grant_o,
    output logic [LW-1:0]    index_o,
    output logic             any_o
);

    // One spare bit so ptr + offset can exceed LANES before wrapping.
    localparam logic [LW:0] c_LANES = (LW+1)'(LANES);

    logic [LW:0] pos;

    // Walk the lanes from ptr upward (with wrap) and grant the first request.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int off = 0; off < LANES; off++) begin
            pos = {1'b0, ptr_i} + (LW+1)'(off);
            if (pos >= c_LANES) begin
                pos = pos - c_LANES;
            end
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                index_o      = pos[LW-1:0];
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/lane_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lane_event_arbiter
// Brief    : Serialises per-lane press pulses into one judged valid/ready
//            event stream. Each press is judged hit/miss in its own cycle,
//            parked in a one-deep per-lane slot if it cannot be granted at
//            once, and granted round-robin. Also keeps a saturating combo
//            count of accepted hits and a sticky lost-press flag.
// Revision : 1.0  initial release
// ============================================================================
module lane_event_arbiter
    import stepmania_pkg::*;
#(
    parameter  int LANES   = DEFAULT_LANES,
    parameter  int COMBO_W = DEFAULT_COMBO_W,
    localparam int LW      = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   press,
    input  logic [LANES-1:0]   note_hit,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [LW-1:0]      evt_lane,
    output logic               evt_hit,
    output logic [COMBO_W-1:0] combo,
    output logic               dropped
);

    localparam logic [COMBO_W-1:0] c_COMBO_MAX = '1;

    // Pending slots and round-robin pointer
    logic [LANES-1:0]   slot_v_q,   slot_v_d;
    logic [LANES-1:0]   slot_hit_q, slot_hit_d;
    logic [LW-1:0]      ptr_q;

    // Output register FSM
    arb_state_t         state_q;
    logic               evt_valid_q;
    logic [LW-1:0]      evt_lane_q;
    logic               evt_hit_q;

    // Score side
    logic [COMBO_W-1:0] combo_q;
    logic               dropped_q;

    // Arbitration wires
    logic [LANES-1:0]   w_cand;
    logic [LANES-1:0]   w_grant;
    logic [LW-1:0]      w_idx;
    logic               w_any;
    logic               w_free;
    logic               w_load;
    logic               w_grant_hit;
    logic               w_accept;
    logic [LANES-1:0]   w_drop;

    // A fresh press competes in the same cycle as the stored ones.
    assign w_cand = slot_v_q | press;

    rr_arbiter #(
        .LANES   (LANES)
    ) u_rr_arbiter (
        .req_i   (w_cand),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .index_o (w_idx),
        .any_o   (w_any)
    );

    // The output register can take a new event when empty or being drained.
    assign w_free   = (state_q == IDLE) || evt_ready;
    assign w_load   = w_free && w_any;
    assign w_accept = evt_valid_q && evt_ready;

    // A stored slot outranks a same-lane press, so its judged bit wins.
    assign w_grant_hit = slot_v_q[w_idx] ? slot_hit_q[w_idx] : note_hit[w_idx];

    // Per-lane slot bookkeeping: clear on grant, park un-granted presses,
    // and flag any press that finds its slot still occupied.
    always_comb begin
        slot_v_d   = slot_v_q;
        slot_hit_d = slot_hit_q;
        w_drop     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_load && w_grant[i]) begin
                // Slot granted; a same-cycle press was not the grant, keep it.
                if (slot_v_q[i] && press[i]) begin
                    slot_v_d[i]   = 1'b1;
                    slot_hit_d[i] = note_hit[i];
                end else begin
                    slot_v_d[i]   = 1'b0;
                end
            end else if (press[i]) begin
                if (slot_v_q[i]) begin
                    w_drop[i]     = 1'b1;
                end else begin
                    slot_v_d[i]   = 1'b1;
                    slot_hit_d[i] = note_hit[i];
                end
            end
        end
    end

    // Slot storage and round-robin pointer advance after each grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v_q   <= '0;
            slot_hit_q <= '0;
            ptr_q      <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            slot_hit_q <= slot_hit_d;
            if (w_load) begin
                ptr_q <= LW'(wrap_inc(int'(w_idx), LANES));
            end
        end
    end

    // Output register FSM: load a grant when free, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_lane_q  <= '0;
            evt_hit_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_any) begin
                        state_q     <= PRESENT;
                        evt_valid_q <= 1'b1;
                        evt_lane_q  <= w_idx;
                        evt_hit_q   <= w_grant_hit;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        if (w_any) begin
                            evt_lane_q <= w_idx;
                            evt_hit_q  <= w_grant_hit;
                        end else begin
                            state_q     <= IDLE;
                            evt_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    evt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Combo counts consecutive accepted hits; a miss restarts it. Lost presses are sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            combo_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (w_accept) begin
                if (evt_hit_q) begin
                    if (combo_q != c_COMBO_MAX) begin
                        combo_q <= combo_q + 1'b1;
                    end
                end else begin
                    combo_q <= '0;
                end
            end
            if (|w_drop) begin
                dropped_q <= 1'b1;
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_lane  = evt_lane_q;
    assign evt_hit   = evt_hit_q;
    assign combo     = combo_q;
    assign dropped   = dropped_q;

endmodule : lane_event_arbiter
`default_nettype wire

// File: tb/tb_lane_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_event_arbiter
// Brief    : Directed self-checking bench for lane_event_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_lane_event_arbiter;

    localparam int LANES   = 4;
    localparam int COMBO_W = 8;

    logic               clk;
    logic               reset;
    logic [LANES-1:0]   press;
    logic [LANES-1:0]   note_hit;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_lane;
    logic               evt_hit;
    logic [COMBO_W-1:0] combo;
    logic               dropped;

    int checks;
    int errors;

    lane_event_arbiter #(
        .LANES     (LANES),
        .COMBO_W   (COMBO_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .press     (press),
        .note_hit  (note_hit),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_lane  (evt_lane),
        .evt_hit   (evt_hit),
        .combo     (combo),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        press = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        press     = '0;
        note_hit  = '0;
        evt_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        checks++; if (evt_lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d want 0", evt_lane); end
        checks++; if (evt_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", evt_hit); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", combo); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b want 0", dropped); end
    endtask

    task automatic test_single_press();
        evt_ready = 1'b1;
        press     = 4'b0100;
        note_hit  = 4'b0100;
        tick();
        press    = '0;
        note_hit = '0;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", evt_valid); end
        checks++; if (evt_lane !== 2'd2) begin errors++; $display("FAIL single_lane: got %0d want 2", evt_lane); end
        checks++; if (evt_hit !== 1'b1) begin errors++; $display("FAIL single_hit: got %b want 1", evt_hit); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL single_combo_before: got %0d want 0", combo); end
        tick();
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL single_combo_after: got %0d want 1", combo); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", evt_valid); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_lane [3];
        logic       exp_hit  [3];
        exp_lane[0] = 2'd0; exp_hit[0] = 1'b0;
        exp_lane[1] = 2'd1; exp_hit[1] = 1'b0;
        exp_lane[2] = 2'd3; exp_hit[2] = 1'b1;
        pulse_reset();
        evt_ready = 1'b1;
        press     = 4'b1011;
        note_hit  = 4'b1000;
        tick();
        press    = '0;
        note_hit = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_lane !== exp_lane[k] || evt_hit !== exp_hit[k]) begin
                errors++;
                $display("FAIL simul_event%0d: got v=%b lane=%0d hit=%b want v=1 lane=%0d hit=%b",
                         k, evt_valid, evt_lane, evt_hit, exp_lane[k], exp_hit[k]);
            end
            tick();
        end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b want 0", evt_valid); end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL simul_combo: got %0d want 1", combo); end
        // Pointer back at 0: lanes 0 and 3 together must come out lane 0 first.
        press = 4'b1001;
        tick();
        press = '0;
        checks++; if (evt_lane !== 2'd0) begin errors++; $display("FAIL simul_ptr_wrap: got %0d want 0", evt_lane); end
        tick();
        checks++; if (evt_lane !== 2'd3) begin errors++; $display("FAIL simul_ptr_second: got %0d want 3", evt_lane); end
        tick();
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL simul_miss_combo: got %0d want 0", combo); end
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        press     = 4'b0001;
        note_hit  = 4'b0001;
        tick();
        press    = 4'b0001;
        note_hit = 4'b0000;
        tick();
        press = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_lane !== 2'd0 || evt_hit !== 1'b1 || dropped !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b lane=%0d hit=%b drop=%b want v=1 lane=0 hit=1 drop=0",
                         k, evt_valid, evt_lane, evt_hit, dropped);
            end
            tick();
        end
        press    = 4'b0001;
        note_hit = 4'b0001;
        tick();
        press    = '0;
        note_hit = '0;
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL stall_dropped: got %b want 1", dropped); end
        checks++; if (evt_lane !== 2'd0 || evt_hit !== 1'b1) begin errors++; $display("FAIL stall_still: got lane=%0d hit=%b want lane=0 hit=1", evt_lane, evt_hit); end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_lane !== 2'd0 || evt_hit !== 1'b0) begin
            errors++;
            $display("FAIL stall_held_press: got v=%b lane=%0d hit=%b want v=1 lane=0 hit=0", evt_valid, evt_lane, evt_hit);
        end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL stall_combo_hit: got %0d want 1", combo); end
        tick();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", evt_valid); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL stall_combo_miss: got %0d want 0", combo); end
    endtask

    task automatic test_combo_saturation();
        pulse_reset();
        evt_ready = 1'b1;
        note_hit  = 4'b0001;
        press     = 4'b0001;
        for (int k = 0; k < 255; k++) begin
            tick();
        end
        press = '0;
        tick();
        tick();
        checks++; if (combo !== 8'd255) begin errors++; $display("FAIL combo_255: got %0d want 255", combo); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL combo_drain: got %b want 0", evt_valid); end
        press = 4'b0001;
        tick();
        press = '0;
        tick();
        checks++; if (combo !== 8'd255) begin errors++; $display("FAIL combo_saturate: got %0d want 255", combo); end
        note_hit = '0;
        press    = 4'b0001;
        tick();
        press = '0;
        tick();
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL combo_miss_reset: got %0d want 0", combo); end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b1;
        press     = 4'b1000;
        note_hit  = 4'b1000;
        tick();
        press = '0;
        tick();
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL midrst_combo_pre: got %0d want 1", combo); end
        evt_ready = 1'b0;
        press     = 4'b0111;
        note_hit  = 4'b0111;
        tick();
        press = '0;
        checks++; if (evt_valid !== 1'b1 || evt_lane !== 2'd0) begin errors++; $display("FAIL midrst_present: got v=%b lane=%0d want v=1 lane=0", evt_valid, evt_lane); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", evt_valid); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL midrst_combo: got %0d want 0", combo); end
        evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: got %b want 0", k, evt_valid); end
        end
    endtask

    task automatic test_back_to_back_same_lane();
        pulse_reset();
        evt_ready = 1'b0;
        press     = 4'b0011;
        note_hit  = 4'b0010;
        tick();
        // Lane 0 presented (miss); lane 1 parked as a hit.
        evt_ready = 1'b1;
        press     = 4'b0010;
        note_hit  = 4'b0000;
        tick();
        press = '0;
        checks++;
        if (evt_valid !== 1'b1 || evt_lane !== 2'd1 || evt_hit !== 1'b1) begin
            errors++;
            $display("FAIL b2b_slot: got v=%b lane=%0d hit=%b want v=1 lane=1 hit=1", evt_valid, evt_lane, evt_hit);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_lane !== 2'd1 || evt_hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stored_press: got v=%b lane=%0d hit=%b want v=1 lane=1 hit=0", evt_valid, evt_lane, evt_hit);
        end
        checks++; if (combo !== 8'd1) begin errors++; $display("FAIL b2b_combo_mid: got %0d want 1", combo); end
        tick();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", evt_valid); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got %b want 0", dropped); end
        checks++; if (combo !== 8'd0) begin errors++; $display("FAIL b2b_combo_end: got %0d want 0", combo); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        press     = '0;
        note_hit  = '0;
        evt_ready = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_backpressure();
        test_combo_saturation();
        test_reset_mid();
        test_back_to_back_same_lane();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lane_event_arbiter
`default_nettype wire

// File: doc/lane_event_arbiter.md
# lane_event_arbiter

Serialises the one-cycle button-press pulses from all arrow lanes into a single judged-event stream for the shared score/feedback logic. Each press is tagged hit or miss by sampling the lane's note-in-zone signal in the press cycle, buffered per lane, then granted round-robin onto one valid/ready output port. A saturating combo counter tracks consecutive accepted hits.

## Interface
- LANES, 4, number of arrow lanes (≥2).
- COMBO_W, 8, combo counter width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- press  in  LANES  per-lane one-cycle press pulses from the debounced edge-detect stage.
- note_hit  in  LANES  level; high while a note sits inside that lane's hit window.
- evt_valid  out  1  event presented.
- evt_ready  in  1  consumer accepts the event this cycle.
- evt_lane  out  $clog2(LANES)  lane index of the presented event.
- evt_hit  out  1  1 = hit, 0 = miss.
- combo  out  COMBO_W  current combo count.
- dropped  out  1  sticky; a press was lost to a full lane slot.

## Operation
- Per lane, one pending slot {valid, hit}. A press on lane i captures hit = note_hit[i] from the same cycle.
- Candidate set each cycle = pending valid bits OR press; a bypassed press competes in its own cycle.
- Output register FSM, two states:
  - IDLE: evt_valid = 0. If the candidate set is non-empty, grant one lane, load the output register, go to PRESENT.
  - PRESENT: evt_valid = 1; evt_lane/evt_hit held stable while evt_ready = 0. On evt_ready = 1, the event is accepted. If the candidate set is non-empty in the same cycle, load the next grant and stay in PRESENT; otherwise go to IDLE.
- Round-robin: search starts at ptr. After every grant, ptr = granted lane + 1, wrapping at LANES.
- Slot rules per lane i in a cycle:
  - Granted this cycle: the slot clears. A same-cycle press on i that was not itself the granted item is stored.
  - Slot full, not granted, press on i: the press is discarded and dropped is set.
  - If both the slot and a press on i exist, the slot wins the grant. The press is stored only when the slot is granted; otherwise it is dropped.
- Combo updates on acceptance only (evt_valid && evt_ready):
  - hit: combo + 1, saturating at 2^COMBO_W − 1.
  - miss: combo = 0.
- dropped clears only on reset.

## Timing
- Reset values: evt_valid 0, evt_lane 0, evt_hit 0, combo 0, dropped 0, ptr 0, all slots empty, state IDLE.
- Latency: a press in cycle n with the output free or being accepted in cycle n gives evt_valid in cycle n+1.
- Throughput: one event per cycle while evt_ready is held high.
- Outputs are registered; there is no combinational path from press or evt_ready to any output.
- Reset mid-operation: pending slots and any presented event are discarded; evt_valid is 0 from the cycle after reset is sampled.
- Simultaneous presses on k lanes emerge on k consecutive accepted cycles in round-robin order from ptr.

## Structure
- Shared package stepmania_pkg: LANES default, lane_idx_t, arb_state_t enum {IDLE, PRESENT}, event struct {lane, hit}.
- Sub-module rr_arbiter: parameterised LANES, inputs req and ptr, output one-hot grant and index. It is purely combinational, and ptr update stays in the parent.

## Test plan
- Single press lane 2, note_hit[2] = 1, evt_ready = 1 -> evt_valid in the next cycle with lane 2, hit 1; combo 0→1.
- Presses on lanes 0,1,3 in the same cycle, ptr = 0, evt_ready = 1 -> events 0,1,3 on three consecutive cycles; ptr ends at 0.
- evt_ready = 0 for 5 cycles while an event is presented, with a second press on the same lane -> lane/hit stay stable; the second press is held; a third press on that lane sets dropped.
- 255 accepted hits then 1 hit (COMBO_W = 8) -> combo saturates at 255; next accepted miss -> combo 0.
- Reset asserted while in PRESENT with 2 pending lanes -> evt_valid 0 and combo 0 on the next cycle; no stale events after reset releases.
- Press on lane 1 in the same cycle its pending slot is granted -> new press stored; emitted on the following accept; dropped stays 0.
